// File: rtl/data_to_axi_pkg.sv
// data_to_axi_pkg
//  Helpers shared by the element-stream and AXI4-Stream blocks.
//  - stats_cnt_t        : 32-bit wrapping statistics counter type
//  - lane_count()       : number of element lanes in one AXI beat
//  - expand_lane_keep() : turns one keep bit per lane into AXI byte keeps
package data_to_axi_pkg;

  typedef logic [31:0] stats_cnt_t;

  // Upper bounds for the generic keep expansion: up to 64 lanes and 1024-bit beats.
  localparam int MAX_LANES      = 64;
  localparam int MAX_KEEP_BYTES = 128;

  function automatic int lane_count(int axi_width, int data_width);
    return axi_width / data_width;
  endfunction

  // Every byte of lane k inherits lane_keep[k]; lanes at or above 'lanes' stay 0.
  function automatic logic [MAX_KEEP_BYTES-1:0] expand_lane_keep(
    logic [MAX_LANES-1:0] lane_keep,
    int                   lanes,
    int                   bytes_per_lane
  );
    logic [MAX_KEEP_BYTES-1:0] byte_keep;
    logic [MAX_KEEP_BYTES-1:0] lane_mask;
    byte_keep = '0;
    lane_mask = (MAX_KEEP_BYTES'(1) << bytes_per_lane) - MAX_KEEP_BYTES'(1);
    for (int k = 0; k < MAX_LANES; k++) begin
      if (k < lanes && lane_keep[k]) begin
        byte_keep = byte_keep | (lane_mask << (k * bytes_per_lane));
      end
    end
    return byte_keep;
  endfunction

endpackage

// File: rtl/data_to_axi_if.sv
// data_i / axi4s
//  data_i : one element per beat stream (data, keep, last, valid, ready).
//           master drives data/keep/last/valid, slave drives ready.
//  axi4s  : AXI4-Stream beat (tdata, tkeep, tlast, tvalid, tready).
//           master drives tdata/tkeep/tlast/tvalid, slave drives tready.
interface data_i #(
  parameter type data_t = logic [31:0]
);
  data_t data;
  logic  keep;
  logic  last;
  logic  valid;
  logic  ready;

  modport master (output data, keep, last, valid, input ready);
  modport slave  (input data, keep, last, valid, output ready);
endinterface

interface axi4s #(
  parameter int AXI_WIDTH = 512
);
  logic [AXI_WIDTH-1:0]   tdata;
  logic [AXI_WIDTH/8-1:0] tkeep;
  logic                   tlast;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/data_to_axi_beat_reg.sv
// axis_beat_reg
//  Single AXI4-Stream output register for any beat producer.
//  Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : capture load_data/keep/last as a new beat (only when free)
//   load_data   : beat payload
//   load_keep   : beat byte keeps
//   load_last   : beat is the last of its packet
//   free        : register can accept a load this cycle (empty or draining)
//   out         : axi4s master side
module axis_beat_reg #(
  parameter int AXI_WIDTH = 512
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [AXI_WIDTH-1:0]   load_data,
  input  logic [AXI_WIDTH/8-1:0] load_keep,
  input  logic                   load_last,
  output logic                   free,
  axi4s.master                   out
);

  assign free = !out.tvalid || out.tready;

  // A load always wins over a drain so a beat can leave and the next one take
  // its place in the same cycle; payload is untouched while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out.tvalid <= 1'b0;
      out.tdata  <= '0;
      out.tkeep  <= '0;
      out.tlast  <= 1'b0;
    end else if (load) begin
      out.tvalid <= 1'b1;
      out.tdata  <= load_data;
      out.tkeep  <= load_keep;
      out.tlast  <= load_last;
    end else if (out.tready) begin
      out.tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/data_to_axi.sv
// data_to_axi
//  Packs an element-per-beat stream into AXI_WIDTH-wide AXI4-Stream beats,
//  element k of a beat in lane k (LSB lane first). A beat closes when all lanes
//  are filled or an element with last arrives; unfilled lanes are zero with
//  tkeep low.
//  Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   in             : data_i slave (element stream)
//   out            : axi4s master (packed beats)
//   beat_count     : beats handed off (only with DATA_TO_AXI_STATS_EN)
//   partial_count  : beats handed off with unfilled lanes (DATA_TO_AXI_STATS_EN)
//  Optional feature macro: DATA_TO_AXI_STATS_EN
module data_to_axi
  import data_to_axi_pkg::*;
#(
  parameter type data_t       = logic [31:0],
  parameter int  AXI_WIDTH    = 512,
  parameter int  DATA_WIDTH   = $bits(data_t),
  parameter int  NUM_ELEMENTS = lane_count(AXI_WIDTH, DATA_WIDTH)
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef DATA_TO_AXI_STATS_EN
  output stats_cnt_t beat_count,
  output stats_cnt_t partial_count,
`endif
  data_i.slave       in,
  axi4s.master       out
);

  localparam int KEEP_WIDTH = AXI_WIDTH / 8;
  localparam int LANE_BYTES = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = $clog2(NUM_ELEMENTS);
  localparam logic [CNT_WIDTH-1:0] LAST_LANE = CNT_WIDTH'(NUM_ELEMENTS - 1);

  if (NUM_ELEMENTS < 2) begin : g_lane_check
    $error("data_to_axi: NUM_ELEMENTS must be at least 2");
  end
  if (DATA_WIDTH % 8 != 0 || AXI_WIDTH % DATA_WIDTH != 0 ||
      NUM_ELEMENTS > MAX_LANES || KEEP_WIDTH > MAX_KEEP_BYTES) begin : g_width_check
    $error("data_to_axi: DATA_WIDTH must be a byte multiple dividing AXI_WIDTH");
  end

  logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] lane_data;
  logic [NUM_ELEMENTS-1:0]                 lane_keep;
  logic [CNT_WIDTH-1:0]                    count;
  logic                                    out_free;
  logic                                    at_last_lane;
  logic                                    accept;
  logic                                    close;
  logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] beat_data;
  logic [NUM_ELEMENTS-1:0]                 beat_lane_keep;
  logic [KEEP_WIDTH-1:0]                   beat_keep;

  // Non-closing elements only touch the accumulator, so they may be taken
  // even while the output register is stalled.
  assign at_last_lane = (count == LAST_LANE);
  assign in.ready     = out_free || (!at_last_lane && !in.last);
  assign accept       = in.valid && in.ready;
  assign close        = accept && (at_last_lane || in.last);

  // Closing beat: stored lanes below count, current element at count, zero above.
  always_comb begin
    beat_data      = '0;
    beat_lane_keep = '0;
    for (int k = 0; k < NUM_ELEMENTS; k++) begin
      if (CNT_WIDTH'(k) < count) begin
        beat_data[k]      = lane_data[k];
        beat_lane_keep[k] = lane_keep[k];
      end else if (CNT_WIDTH'(k) == count) begin
        beat_data[k]      = in.data;
        beat_lane_keep[k] = in.keep;
      end
    end
  end

  assign beat_keep = KEEP_WIDTH'(expand_lane_keep(MAX_LANES'(beat_lane_keep),
                                                  NUM_ELEMENTS, LANE_BYTES));

  // Accumulator: positional fill, cleared whenever a beat closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      lane_data <= '0;
      lane_keep <= '0;
    end else if (close) begin
      count     <= '0;
      lane_data <= '0;
      lane_keep <= '0;
    end else if (accept) begin
      lane_data[count] <= in.data;
      lane_keep[count] <= in.keep;
      count            <= count + CNT_WIDTH'(1);
    end
  end

  axis_beat_reg #(
    .AXI_WIDTH (AXI_WIDTH)
  ) u_beat_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (close),
    .load_data (beat_data),
    .load_keep (beat_keep),
    .load_last (in.last),
    .free      (out_free),
    .out       (out)
  );

`ifdef DATA_TO_AXI_STATS_EN
  logic beat_partial;

  // beat_partial travels with the beat in the output register so the
  // handshake counts the beat actually leaving, not the one being loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_partial  <= 1'b0;
      beat_count    <= '0;
      partial_count <= '0;
    end else begin
      if (close) begin
        beat_partial <= !at_last_lane;
      end
      if (out.tvalid && out.tready) begin
        beat_count <= beat_count + stats_cnt_t'(1);
        if (beat_partial) begin
          partial_count <= partial_count + stats_cnt_t'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_to_axi.sv
// tb_data_to_axi
//  Drives element streams into data_to_axi (32-bit elements, 128-bit beats,
//  4 lanes) and compares every emitted beat with a packet-level model that
//  groups accepted elements into beats of four or up to a last element.
module tb_data_to_axi;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  data_i #(.data_t(logic [31:0])) in_if ();
  axi4s  #(.AXI_WIDTH(128))       out_if ();

`ifdef DATA_TO_AXI_STATS_EN
  logic [31:0] beat_count;
  logic [31:0] partial_count;
`endif

  data_to_axi #(
    .data_t    (logic [31:0]),
    .AXI_WIDTH (128)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef DATA_TO_AXI_STATS_EN
    .beat_count    (beat_count),
    .partial_count (partial_count),
`endif
    .in            (in_if),
    .out           (out_if)
  );

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    bit           partial;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       obs_log[$];
  logic [31:0] cur_data[$];
  logic        cur_keep[$];

  int checks = 0;
  int errors = 0;
  int step_count = 0;
  int beats_seen = 0;
  int partials_seen = 0;
  int stall_left = 0;
  bit rand_ready = 0;
  bit acc_seen = 0;
  bit prev_stall = 0;
  logic [127:0] snap_data;
  logic [15:0]  snap_keep;
  logic         snap_last;

  // Reference model: accepted elements are grouped per packet, four per beat.
  function automatic void model_push(logic [31:0] d, logic k, logic l);
    beat_t b;
    cur_data.push_back(d);
    cur_keep.push_back(k);
    if (cur_data.size() == 4 || l) begin
      b.data    = '0;
      b.keep    = '0;
      b.last    = l;
      b.partial = (cur_data.size() < 4);
      foreach (cur_data[i]) begin
        b.data = b.data | (128'(cur_data[i]) << (32 * i));
        if (cur_keep[i]) b.keep = b.keep | (16'hF << (4 * i));
      end
      exp_q.push_back(b);
      cur_data.delete();
      cur_keep.delete();
    end
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    cur_data.delete();
    cur_keep.delete();
    prev_stall    = 0;
    beats_seen    = 0;
    partials_seen = 0;
  endfunction

  // One clock: monitor at negedge, then advance to just after the next posedge.
  task automatic step();
    beat_t e;
    logic  exp_ready;
    @(negedge clk);
    step_count++;
    exp_ready = !(out_if.tvalid && !out_if.tready) ||
                (cur_data.size() != 3 && !in_if.last);
    checks++;
    if (in_if.ready !== exp_ready) begin
      errors++;
      $display("[TB] FAIL in_ready: got %b expected %b", in_if.ready, exp_ready);
    end
    acc_seen = in_if.valid && in_if.ready;
    if (prev_stall) begin
      checks++;
      if (out_if.tvalid !== 1'b1 || out_if.tdata !== snap_data ||
          out_if.tkeep !== snap_keep || out_if.tlast !== snap_last) begin
        errors++;
        $display("[TB] FAIL stall_stable: got v=%b d=%h k=%h l=%b expected v=1 d=%h k=%h l=%b",
                 out_if.tvalid, out_if.tdata, out_if.tkeep, out_if.tlast,
                 snap_data, snap_keep, snap_last);
      end
    end
    if (out_if.tvalid && out_if.tready) begin
      checks++;
      beats_seen++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_beat: got d=%h k=%h l=%b expected no beat",
                 out_if.tdata, out_if.tkeep, out_if.tlast);
      end else begin
        e = exp_q.pop_front();
        if (e.partial) partials_seen++;
        if (out_if.tdata !== e.data || out_if.tkeep !== e.keep || out_if.tlast !== e.last) begin
          errors++;
          $display("[TB] FAIL beat: got d=%h k=%h l=%b expected d=%h k=%h l=%b",
                   out_if.tdata, out_if.tkeep, out_if.tlast, e.data, e.keep, e.last);
        end
      end
      obs_log.push_back('{out_if.tdata, out_if.tkeep, out_if.tlast, 1'b0});
    end
    prev_stall = out_if.tvalid && !out_if.tready;
    snap_data  = out_if.tdata;
    snap_keep  = out_if.tkeep;
    snap_last  = out_if.tlast;
    if (acc_seen) model_push(in_if.data, in_if.keep, in_if.last);
    @(posedge clk);
    #1;
    if (stall_left > 0) begin
      stall_left--;
      out_if.tready = (stall_left == 0);
    end else if (rand_ready) begin
      out_if.tready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic send(logic [31:0] d, logic k, logic l);
    int n;
    n = 0;
    in_if.valid = 1'b1;
    in_if.data  = d;
    in_if.keep  = k;
    in_if.last  = l;
    do begin
      step();
      n++;
    end while (!acc_seen && n < 100);
    checks++;
    if (!acc_seen) begin
      errors++;
      $display("[TB] FAIL send_timeout: got no accept after %0d cycles expected accept", n);
    end
    in_if.valid = 1'b0;
    in_if.last  = 1'b0;
  endtask

  task automatic flush();
    int n;
    n = 0;
    stall_left    = 0;
    rand_ready    = 0;
    out_if.tready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    in_if.valid   = 1'b0;
    in_if.data    = '0;
    in_if.keep    = 1'b0;
    in_if.last    = 1'b0;
    out_if.tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (out_if.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid: got %b expected 0", out_if.tvalid); end
    if (out_if.tdata !== '0) begin errors++; $display("[TB] FAIL reset_tdata: got %h expected 0", out_if.tdata); end
    if (out_if.tkeep !== '0) begin errors++; $display("[TB] FAIL reset_tkeep: got %h expected 0", out_if.tkeep); end
    if (out_if.tlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_tlast: got %b expected 0", out_if.tlast); end
    if (in_if.ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", in_if.ready); end
    model_clear();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_packets();
    int s0;
    out_if.tready = 1'b1;
    obs_log.delete();
    s0 = step_count;
    for (int i = 1; i <= 8; i++) send(32'(i), 1'b1, i == 8);
    checks++;
    if (step_count - s0 != 8) begin
      errors++;
      $display("[TB] FAIL full_throughput: got %0d cycles expected 8", step_count - s0);
    end
    flush();
    checks++;
    if (obs_log.size() != 2) begin
      errors++;
      $display("[TB] FAIL full_beats: got %0d beats expected 2", obs_log.size());
    end else begin
      checks++;
      if (obs_log[0].data !== 128'h00000004_00000003_00000002_00000001 ||
          obs_log[0].keep !== 16'hFFFF || obs_log[0].last !== 1'b0) begin
        errors++;
        $display("[TB] FAIL full_beat0: got d=%h k=%h l=%b expected d=4_3_2_1 k=ffff l=0",
                 obs_log[0].data, obs_log[0].keep, obs_log[0].last);
      end
      checks++;
      if (obs_log[1].data !== 128'h00000008_00000007_00000006_00000005 ||
          obs_log[1].keep !== 16'hFFFF || obs_log[1].last !== 1'b1) begin
        errors++;
        $display("[TB] FAIL full_beat1: got d=%h k=%h l=%b expected d=8_7_6_5 k=ffff l=1",
                 obs_log[1].data, obs_log[1].keep, obs_log[1].last);
      end
    end
  endtask

  task automatic test_partial();
    obs_log.delete();
    for (int i = 1; i <= 6; i++) send(32'(i), 1'b1, i == 6);
    flush();
    checks++;
    if (obs_log.size() != 2) begin
      errors++;
      $display("[TB] FAIL partial_beats: got %0d beats expected 2", obs_log.size());
    end else if (obs_log[1].data !== 128'h00000000_00000000_00000006_00000005 ||
                 obs_log[1].keep !== 16'h00FF || obs_log[1].last !== 1'b1) begin
      errors++;
      $display("[TB] FAIL partial_beat1: got d=%h k=%h l=%b expected d=0_0_6_5 k=00ff l=1",
               obs_log[1].data, obs_log[1].keep, obs_log[1].last);
    end
  endtask

  task automatic test_single();
    checks++;
    if (out_if.tvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_idle: got tvalid %b expected 0", out_if.tvalid);
    end
    send(32'hAA, 1'b1, 1'b1);
    checks++;
    if (out_if.tvalid !== 1'b1 || out_if.tdata !== 128'hAA ||
        out_if.tkeep !== 16'h000F || out_if.tlast !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_beat: got v=%b d=%h k=%h l=%b expected v=1 d=aa k=000f l=1",
               out_if.tvalid, out_if.tdata, out_if.tkeep, out_if.tlast);
    end
    flush();
  endtask

  task automatic test_keep_zero();
    obs_log.delete();
    send(32'h11, 1'b1, 1'b0);
    send(32'h22, 1'b1, 1'b0);
    send(32'h33, 1'b0, 1'b0);
    send(32'h44, 1'b1, 1'b1);
    flush();
    checks++;
    if (obs_log.size() != 1) begin
      errors++;
      $display("[TB] FAIL keep0_beats: got %0d beats expected 1", obs_log.size());
    end else if (obs_log[0].data !== 128'h00000044_00000033_00000022_00000011 ||
                 obs_log[0].keep !== 16'hF0FF || obs_log[0].last !== 1'b1) begin
      errors++;
      $display("[TB] FAIL keep0_beat: got d=%h k=%h l=%b expected d=44_33_22_11 k=f0ff l=1",
               obs_log[0].data, obs_log[0].keep, obs_log[0].last);
    end
  endtask

  task automatic test_backpressure();
    obs_log.delete();
    out_if.tready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) begin
        out_if.tready = 1'b0;
        stall_left    = 10;
      end
      send($urandom, ($urandom_range(0, 3) != 0), i == 11);
    end
    flush();
    checks++;
    if (obs_log.size() != 3) begin
      errors++;
      $display("[TB] FAIL bp_beats: got %0d beats expected 3", obs_log.size());
    end
  endtask

  task automatic test_random();
    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) step();
      send($urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0));
    end
    send($urandom, 1'b1, 1'b1);
    flush();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d[4];
    out_if.tready = 1'b0;
    for (int i = 0; i < 6; i++) send($urandom, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (out_if.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_tvalid: got %b expected 0", out_if.tvalid); end
    if (out_if.tdata !== '0) begin errors++; $display("[TB] FAIL mid_reset_tdata: got %h expected 0", out_if.tdata); end
    if (in_if.ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_ready: got %b expected 1", in_if.ready); end
`ifdef DATA_TO_AXI_STATS_EN
    checks++;
    if (beat_count !== 32'd0 || partial_count !== 32'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset_stats: got %0d/%0d expected 0/0", beat_count, partial_count);
    end
`endif
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_if.tready = 1'b1;
    obs_log.delete();
    for (int i = 0; i < 4; i++) begin
      d[i] = $urandom;
      send(d[i], 1'b1, 1'b0);
    end
    flush();
    checks++;
    if (obs_log.size() != 1) begin
      errors++;
      $display("[TB] FAIL mid_reset_beats: got %0d beats expected 1", obs_log.size());
    end else if (obs_log[0].data !== {d[3], d[2], d[1], d[0]} ||
                 obs_log[0].keep !== 16'hFFFF || obs_log[0].last !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_beat: got d=%h k=%h l=%b expected d=%h k=ffff l=0",
               obs_log[0].data, obs_log[0].keep, obs_log[0].last, {d[3], d[2], d[1], d[0]});
    end
  endtask

  initial begin
    test_reset();
    test_full_packets();
    test_partial();
    test_single();
    test_keep_zero();
    test_backpressure();
    test_random();
    test_reset_mid();
    send(32'h5, 1'b1, 1'b1);
    flush();
`ifdef DATA_TO_AXI_STATS_EN
    checks++;
    if (beat_count !== 32'(beats_seen) || partial_count !== 32'(partials_seen)) begin
      errors++;
      $display("[TB] FAIL stats: got %0d/%0d expected %0d/%0d",
               beat_count, partial_count, beats_seen, partials_seen);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
